ex_stage: RTL and testbench

- Execute stage; sits directly upstream of the memory-access stage.
- Consumes the decoded instruction (IR, PC, two register operands) and produces IR_out, PC_out, Z_out and Addr_out. These feed the memory stage's IR_in, PC_in, Z_in and Addr.
- Single-cycle ALU for arithmetic, logic and address generation. Iterative 32-cycle multiplier, during which the stage stalls upstream.

---
 rtl/ex_stage_pkg.sv | 32 +++
 rtl/ex_stage_mul_iter.sv | 61 ++++++
 rtl/ex_stage.sv | 171 +++++++++++++++++
 tb/tb_ex_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, opcode map and FSM states.
// The multiplier is built only when EX_MUL_EN is defined.
package ex_stage_pkg;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 32;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h06;
    localparam logic [5:0] OP_LH   = 6'h07;
    localparam logic [5:0] OP_LD   = 6'h08;
    localparam logic [5:0] OP_SW   = 6'h09;
    localparam logic [5:0] OP_SH   = 6'h0A;
    localparam logic [5:0] OP_SD   = 6'h0B;
    localparam logic [5:0] OP_MUL  = 6'h0C;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of an unsigned product.
// One iteration per clock; done is asserted combinationally during the final iteration.
module mul_iter
    import ex_stage_pkg::*;
#(
    parameter int W   = WIDTH,
    parameter int CYC = MUL_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product_lo
);

    localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC - 1);

    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplier;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic [W-1:0]  w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign busy       = r_busy;
    assign done       = r_busy && (r_count == LAST);
    assign product_lo = w_acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (!r_busy) begin
            if (start) begin
                r_mcand  <= a;
                r_mplier <= b;
                r_acc    <= '0;
                r_count  <= '0;
                r_busy   <= 1'b1;
            end
        end else begin
            // Bits shifted past W are discarded: only the low product is kept.
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/address generation, plus an iterative multiplier
// that stalls upstream while busy (present only when EX_MUL_EN is defined).
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   IR_in,
    input  logic [WIDTH-3:0]   PC_in,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic [WIDTH-1:0]   IR_out,
    output logic [WIDTH-3:0]   PC_out,
    output logic [WIDTH-1:0]   Z_out,
    output logic [WIDTH-1:0]   Addr_out,
    output logic               ovf,
    output logic               stall
);

    logic [5:0]       w_opcode;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_eaddr;
    logic [WIDTH-1:0] w_z;
    logic [WIDTH-1:0] w_addr;
    logic             w_ovf;

    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-3:0] r_pc;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_addr;
    logic             r_ovf;

    assign w_opcode = IR_in[31:26];
    assign w_imm    = {{(WIDTH-16){IR_in[15]}}, IR_in[15:0]};
    assign w_sum    = A_in + B_in;
    assign w_diff   = A_in - B_in;
    assign w_eaddr  = A_in + w_imm;

    // Unknown opcodes (and MUL, which has its own path) fall to the zero default.
    always_comb begin
        w_z    = '0;
        w_addr = '0;
        w_ovf  = 1'b0;
        case (w_opcode)
            OP_ADD: begin
                w_z   = w_sum;
                w_ovf = add_ovf(A_in[WIDTH-1], B_in[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_SUB: begin
                w_z   = w_diff;
                w_ovf = add_ovf(A_in[WIDTH-1], ~B_in[WIDTH-1], w_diff[WIDTH-1]);
            end
            OP_AND:  w_z = A_in & B_in;
            OP_OR:   w_z = A_in | B_in;
            OP_ADDI: begin
                w_z   = w_eaddr;
                w_ovf = add_ovf(A_in[WIDTH-1], w_imm[WIDTH-1], w_eaddr[WIDTH-1]);
            end
            OP_LW, OP_LH, OP_LD: w_addr = w_eaddr;
            OP_SW, OP_SH, OP_SD: begin
                w_addr = w_eaddr;
                w_z    = B_in;
            end
            default: ;
        endcase
    end

    assign IR_out   = r_ir;
    assign PC_out   = r_pc;
    assign Z_out    = r_z;
    assign Addr_out = r_addr;
    assign ovf      = r_ovf;

`ifdef EX_MUL_EN
    ex_state_e        r_state;
    logic             r_stall;
    logic [WIDTH-1:0] r_ir_lat;
    logic [WIDTH-3:0] r_pc_lat;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;

    assign w_mul_start = (r_state == ST_IDLE) && (w_opcode == OP_MUL) && !w_mul_busy;
    assign stall       = r_stall;

    mul_iter #(
        .W   (WIDTH),
        .CYC (MUL_CYCLES)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_mul_start),
        .a          (A_in),
        .b          (B_in),
        .busy       (w_mul_busy),
        .done       (w_mul_done),
        .product_lo (w_mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_stall  <= 1'b0;
            r_ir_lat <= '0;
            r_pc_lat <= '0;
            r_ir     <= '0;
            r_pc     <= '0;
            r_z      <= '0;
            r_addr   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mul_start) begin
                        // Emit a bubble now; the MUL itself retires when the multiplier finishes.
                        r_ir_lat <= IR_in;
                        r_pc_lat <= PC_in;
                        r_stall  <= 1'b1;
                        r_state  <= ST_BUSY;
                        r_ir     <= '0;
                        r_pc     <= '0;
                        r_z      <= '0;
                        r_addr   <= '0;
                        r_ovf    <= 1'b0;
                    end else begin
                        r_ir   <= IR_in;
                        r_pc   <= PC_in;
                        r_z    <= w_z;
                        r_addr <= w_addr;
                        r_ovf  <= w_ovf;
                    end
                end
                ST_BUSY: begin
                    if (w_mul_done) begin
                        r_ir    <= r_ir_lat;
                        r_pc    <= r_pc_lat;
                        r_z     <= w_mul_prod;
                        r_addr  <= '0;
                        r_ovf   <= 1'b0;
                        r_stall <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign stall = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir   <= '0;
            r_pc   <= '0;
            r_z    <= '0;
            r_addr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_ir   <= IR_in;
            r_pc   <= PC_in;
            r_z    <= w_z;
            r_addr <= w_addr;
            r_ovf  <= w_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: cycle-level reference model feeding an expected queue,
// per-cycle compare process, and hand-computed literal checks; adapts to EX_MUL_EN.
module tb_ex_stage;
    import ex_stage_pkg::*;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int EW = 128;

    logic        clk;
    logic        rst_n;
    logic [31:0] IR_in;
    logic [29:0] PC_in;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic [31:0] IR_out;
    logic [29:0] PC_out;
    logic [31:0] Z_out;
    logic [31:0] Addr_out;
    logic        ovf;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [29:0]   pc_ctr = 30'h100;

    ex_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .IR_in    (IR_in),
        .PC_in    (PC_in),
        .A_in     (A_in),
        .B_in     (B_in),
        .IR_out   (IR_out),
        .PC_out   (PC_out),
        .Z_out    (Z_out),
        .Addr_out (Addr_out),
        .ovf      (ovf),
        .stall    (stall)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    int          mul_left = 0;
    logic [31:0] mul_ir, mul_prod;
    logic [29:0] mul_pc;

    always @(posedge clk) begin
        logic [31:0] e_ir, e_z, e_addr, ea;
        logic [29:0] e_pc;
        logic        e_ovf, e_stall;
        longint      sa, sb, sr, simm;
        logic [5:0]  op;
        e_ir = '0; e_pc = '0; e_z = '0; e_addr = '0; e_ovf = 1'b0; e_stall = 1'b0;
        op   = IR_in[31:26];
        sa   = longint'($signed(A_in));
        sb   = longint'($signed(B_in));
        simm = longint'($signed(IR_in[15:0]));
        ea   = 32'(sa + simm);
        if (!rst_n) begin
            mul_left = 0;
        end else if (mul_left > 0) begin
            mul_left = mul_left - 1;
            if (mul_left == 0) begin
                e_ir = mul_ir; e_pc = mul_pc; e_z = mul_prod;
            end else begin
                e_stall = 1'b1;
            end
        end else if (MUL_EN && op == OP_MUL) begin
            mul_left = 32;
            mul_ir   = IR_in;
            mul_pc   = PC_in;
            mul_prod = 32'(64'(A_in) * 64'(B_in));
            e_stall  = 1'b1;
        end else begin
            e_ir = IR_in;
            e_pc = PC_in;
            case (op)
                OP_ADD:  begin sr = sa + sb;   e_z = 32'(sr); e_ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
                OP_SUB:  begin sr = sa - sb;   e_z = 32'(sr); e_ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
                OP_ADDI: begin sr = sa + simm; e_z = 32'(sr); e_ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
                OP_AND:  e_z = A_in & B_in;
                OP_OR:   e_z = A_in | B_in;
                OP_LW, OP_LH, OP_LD: e_addr = ea;
                OP_SW, OP_SH, OP_SD: begin e_addr = ea; e_z = B_in; end
                default: ;
            endcase
        end
        exp_q.push_back({e_ir, e_pc, e_z, e_addr, e_ovf, e_stall});
    end

    // ---------------- scoreboard ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check32("cyc_IR_out",   IR_out,          e[127:96]);
            check32("cyc_PC_out",   {2'b00, PC_out}, {2'b00, e[95:66]});
            check32("cyc_Z_out",    Z_out,           e[65:34]);
            check32("cyc_Addr_out", Addr_out,        e[33:2]);
            check32("cyc_ovf",      {31'd0, ovf},    {31'd0, e[1]});
            check32("cyc_stall",    {31'd0, stall},  {31'd0, e[0]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] op, input logic [15:0] imm,
                         input logic [31:0] a, input logic [31:0] b);
        IR_in  = {op, 10'h2A5, imm};
        PC_in  = pc_ctr;
        A_in   = a;
        B_in   = b;
        pc_ctr = pc_ctr + 30'd3;
    endtask

    task automatic exec(input logic [5:0] op, input logic [15:0] imm,
                        input logic [31:0] a, input logic [31:0] b);
        drive(op, imm, a, b);
        @(negedge clk);
    endtask

    task automatic wait_stall_low(output int n);
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] sv_ir;
    logic [29:0] sv_pc;
    int          n;

    initial begin
        rst_n = 1'b0;
        drive(OP_ADD, 16'h0, 32'd3, 32'd4);
        repeat (2) @(negedge clk);
        check32("rst_IR_out", IR_out, 32'h0);
        check32("rst_Z_out",  Z_out,  32'h0);
        check32("rst_stall",  {31'd0, stall}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check32("post_rst_add", Z_out, 32'd7);

        exec(OP_ADD, 16'h0, 32'h7FFFFFFF, 32'h1);
        check32("add_ovf_z",   Z_out, 32'h80000000);
        check32("add_ovf_flag", {31'd0, ovf}, 32'h1);
        exec(OP_SUB, 16'h0, 32'd5, 32'd7);
        check32("sub_z",   Z_out, 32'hFFFFFFFE);
        check32("sub_ovf", {31'd0, ovf}, 32'h0);
        exec(OP_SUB, 16'h0, 32'h80000000, 32'h1);
        check32("sub_ovf_flag", {31'd0, ovf}, 32'h1);
        exec(OP_AND, 16'h0, 32'hF0F01234, 32'h0FF0FF00);
        check32("and_z", Z_out, 32'h00F01200);
        exec(OP_OR, 16'h0, 32'hF0F01234, 32'h0FF0FF00);
        check32("or_z", Z_out, 32'hFFF0FF34);
        exec(OP_ADDI, 16'hFFFF, 32'd10, 32'h0);
        check32("addi_z", Z_out, 32'd9);
        exec(OP_ADDI, 16'h0001, 32'h7FFFFFFF, 32'h0);
        check32("addi_ovf", {31'd0, ovf}, 32'h1);

        drive(OP_SW, 16'hFFFC, 32'h100, 32'hDEADBEEF);
        sv_ir = IR_in; sv_pc = PC_in;
        @(negedge clk);
        check32("sw_addr", Addr_out, 32'h000000FC);
        check32("sw_z",    Z_out,    32'hDEADBEEF);
        check32("sw_ir",   IR_out,   sv_ir);
        check32("sw_pc",   {2'b00, PC_out}, {2'b00, sv_pc});
        exec(OP_LW, 16'h0010, 32'h1000, 32'h55);
        check32("lw_addr", Addr_out, 32'h00001010);
        check32("lw_z",    Z_out,    32'h0);
        exec(OP_LD, 16'h0001, 32'h7FFFFFFF, 32'h0);
        check32("ld_addr_noovf", {31'd0, ovf}, 32'h0);
        drive(OP_NOP, 16'h0, 32'h1234, 32'h5678);
        IR_in = '0;
        @(negedge clk);
        check32("nop_z", Z_out, 32'h0);
        exec(6'h3F, 16'h1234, 32'h1, 32'h2);
        check32("unk_z", Z_out, 32'h0);

        // MUL 12345*678 followed by a held ADD
        drive(OP_MUL, 16'h0, 32'd12345, 32'd678);
        sv_ir = IR_in; sv_pc = PC_in;
        @(negedge clk);
        drive(OP_ADD, 16'h0, 32'd2, 32'd3);
        wait_stall_low(n);
        check32("mul_stall_cycles", n, MUL_EN ? 32'd32 : 32'd0);
        check32("mul_z",  Z_out, MUL_EN ? 32'd8369910 : 32'd0);
        check32("mul_ir", IR_out, sv_ir);
        check32("mul_pc", {2'b00, PC_out}, {2'b00, sv_pc});
        @(negedge clk);
        check32("after_mul_add", Z_out, 32'd5);

        exec(OP_MUL, 16'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(OP_NOP, 16'h0, 32'h0, 32'h0);
        wait_stall_low(n);
        check32("mul_max_z", Z_out, MUL_EN ? 32'h1 : 32'h0);

        // Back-to-back multiplies
        exec(OP_MUL, 16'h0, 32'd3, 32'd5);
        drive(OP_MUL, 16'h0, 32'd7, 32'd9);
        wait_stall_low(n);
        check32("mul_b2b_first", Z_out, MUL_EN ? 32'd15 : 32'd0);
        @(negedge clk);
        drive(OP_NOP, 16'h0, 32'h0, 32'h0);
        wait_stall_low(n);
        check32("mul_b2b_cycles", n, MUL_EN ? 32'd32 : 32'd0);
        check32("mul_b2b_second", Z_out, MUL_EN ? 32'd63 : 32'd0);

        // Reset in the middle of a multiply
        exec(OP_MUL, 16'h0, 32'd100, 32'd200);
        drive(OP_ADD, 16'h0, 32'd1, 32'd1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check32("mulrst_z",     Z_out, 32'h0);
        check32("mulrst_ir",    IR_out, 32'h0);
        check32("mulrst_stall", {31'd0, stall}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check32("mulrst_add", Z_out, 32'd2);
        drive(OP_NOP, 16'h0, 32'h0, 32'h0);
        repeat (40) @(negedge clk);
        check32("mulrst_no_late_result", Z_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
